ahb_i2c_slave_if: RTL
=====================

Name: ahb_i2c_slave_if

Overview:
AHB-Lite slave front end of the AHB-to-I2C bridge; sits directly downstream of the AHB master and consumes its haddr/htrans/hsize/hburst/hwrite/hwdata stream.
Decodes a small register map, buffers transmit bytes in a TX FIFO, and drives hready/hresp back to the master.
Presents a byte-stream plus command interface to the I2C engine.

Parameters:
BASE_ADDR, 32'h0000_0000, base of the 16-byte register window; decode uses haddr[31:4] only.
FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.

Ports:
Hclk  input  1  system clock, rising edge
Hreset  input  1  synchronous reset, active-low
hsel  input  1  slave select
haddr  input  32  address, address phase
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hsize  input  3  transfer size; only 3'b010 (word) is legal
hburst  input  3  burst type; ignored, every beat decoded independently
hwrite  input  1  1 = write
hwdata  input  32  write data, data phase; bit 0 is the LSB
hready  output  1  transfer done / wait
hresp  output  1  0 OKAY, 1 ERROR
hrdata  output  32  read data, data phase
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO not empty
tx_ready  input  1  I2C engine pops the head when tx_valid && tx_ready
i2c_go  output  1  one-cycle start pulse
i2c_rw  output  1  CTRL.rw
i2c_addr  output  7  target slave address
i2c_busy  input  1  engine busy
i2c_ack_err  input  1  one-cycle NACK pulse

Behaviour:
- Reset (Hreset==0 at a clock edge):
  - hready=1, hresp=0, hrdata=0, i2c_go=0.
  - All registers 0; FIFO empty, so tx_valid=0.
  - Any pending wait or error sequence is abandoned; the next cycle is in IDLE.
- Register map (offset = haddr[3:2]):
  - 0 CTRL: bit0 go (write-only, self-clearing), bit1 rw.
  - 1 STATUS: bit0 fifo_empty, bit1 fifo_full, bit2 busy, bit3 ack_err (sticky, write-1-clear), bits[7:4] fifo count.
  - 2 TXDATA: write-only; a write pushes hwdata[7:0].
  - 3 SLV_ADDR: bits[6:0].
  - Reads of TXDATA return 0.
- Address phase is accepted when hsel && htrans[1] && hready; all address/control is registered. IDLE/BUSY or hsel=0 -> no action, OKAY.
- FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
  - IDLE -> DATA on an accepted legal transfer.
  - IDLE -> ERR1 on an accepted illegal transfer: hsize!=010, haddr[1:0]!=0, or haddr[31:4]!=BASE_ADDR[31:4].
  - DATA: write commits using hwdata this cycle; read drives hrdata combinationally from the registered offset; hready=1 (zero wait states). A new accepted transfer in the same cycle is pipelined (DATA->DATA or DATA->ERR1); otherwise -> IDLE.
  - DATA with a TXDATA write and FIFO full: hready=0 -> WAIT. WAIT holds hready=0 until the FIFO has space, then pushes and completes. No timeout.
  - ERR1: hready=0, hresp=1. ERR2: hready=1, hresp=1. The master may drop or issue the next address in ERR2.
- FIFO full with a simultaneous pop and push: the pop frees an entry and the push completes the same cycle, with no wait state.
- i2c_go pulses for one cycle on the clock after a CTRL write with bit0=1; i2c_rw and i2c_addr are continuous from the registers.
- ack_err: set by the i2c_ack_err pulse; cleared by a STATUS write with bit3=1. Set and clear in the same cycle -> set wins.
- Count width is $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package ahb_i2c_pkg:
  - HTRANS_* and HRESP_* codes.
  - Register offsets REG_CTRL/REG_STATUS/REG_TXDATA/REG_SLV_ADDR.
  - STATUS bit indices.
  - FSM state encoding.
- Sub-module ahb_i2c_txfifo: parameterised synchronous FIFO with push/pop/full/empty/count.

Test Plan:
- Reset, then read STATUS -> hrdata=32'h0000_0001, hresp=0, hready=1 throughout.
- Write SLV_ADDR=32'h50, then CTRL=32'h3 -> i2c_addr=7'h50, i2c_rw=1, i2c_go high for exactly one cycle.
- With tx_ready=0, INCR back-to-back writes to TXDATA of 8'hA1..8'hA5 (FIFO_DEPTH=4):
  - The 5th write holds hready=0.
  - Raise tx_ready for one cycle -> 8'hA1 popped, 5th write completes.
  - tx_data sequence A2..A5.
- Word read at haddr=32'h0000_0010, then a write with hsize=3'b000 -> each produces ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); no register changes.
- Pulse i2c_ack_err -> STATUS bit3=1. Write STATUS=32'h8 in the same cycle as a new pulse -> bit3 stays 1. Write 32'h8 alone -> bit3=0.
- Assert Hreset=0 during WAIT -> next cycle hready=1, FIFO empty, tx_valid=0.

Source files
------------

// File: rtl/ahb_i2c_pkg.sv
// ---------------------------------------------------------------------------
// ahb_i2c_pkg
// Shared constants for the AHB-Lite front end of the AHB-to-I2C bridge:
// AHB transfer/response codes, register offsets, CTRL/STATUS bit positions
// and the slave-interface FSM state encoding.
// ---------------------------------------------------------------------------
package ahb_i2c_pkg;

  // AHB transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB responses
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Only word transfers are legal
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Register offsets (haddr[3:2])
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_TXDATA   = 2'd2;
  localparam logic [1:0] REG_SLV_ADDR = 2'd3;

  // CTRL bits
  localparam int CTRL_GO = 0;
  localparam int CTRL_RW = 1;

  // STATUS bits
  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_ACK_ERR = 3;
  localparam int STAT_CNT_LSB = 4;

  // Slave-interface FSM
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // NONSEQ and SEQ start a transfer; IDLE and BUSY do nothing.
  function automatic logic htrans_active(input logic [1:0] trans);
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_i2c_txfifo.sv
// ---------------------------------------------------------------------------
// ahb_i2c_txfifo
// Synchronous FIFO holding bytes queued for the I2C engine. The head entry is
// presented combinationally so the engine sees tx_data while tx_valid is high.
// A push while full is accepted when a pop happens in the same cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_data   write request and data
//   pop               remove head entry (ignored when empty)
//   head              current head entry
//   full, empty       occupancy flags
//   count             number of stored entries
// ---------------------------------------------------------------------------
module ahb_i2c_txfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ahb_i2c_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_i2c_slave_if
// AHB-Lite slave front end of the AHB-to-I2C bridge. Decodes a 4-register
// window (CTRL, STATUS, TXDATA, SLV_ADDR), queues TXDATA writes in a FIFO for
// the I2C engine and answers with zero-wait OKAY, FIFO-full wait states or a
// two-cycle ERROR response.
// Ports:
//   Hclk, Hreset                clock, synchronous active-low reset
//   hsel/haddr/htrans/hsize/
//   hburst/hwrite/hwdata        AHB-Lite request from the master
//   hready/hresp/hrdata         AHB-Lite response
//   tx_data/tx_valid/tx_ready   byte stream to the I2C engine
//   i2c_go/i2c_rw/i2c_addr      command to the I2C engine
//   i2c_busy/i2c_ack_err        engine status
// ---------------------------------------------------------------------------
module ahb_i2c_slave_if
  import ahb_i2c_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        i2c_go,
  output logic        i2c_rw,
  output logic [6:0]  i2c_addr,
  input  logic        i2c_busy,
  input  logic        i2c_ack_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]    state_reg, state_next;
  logic [1:0]    off_reg;
  logic          write_reg;
  logic          rw_reg;
  logic [6:0]    slv_addr_reg;
  logic          ack_err_reg;
  logic          go_reg;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          accept, legal, in_data, wr_tx, reg_wr;
  logic          fifo_pop, fifo_space, fifo_push, hready_int;
  logic [31:0]   status_word;
  logic          unused_bits;

  // Every beat is decoded on its own, so the burst type carries no meaning.
  assign unused_bits = ^{hburst, hwdata[31:8]};

  assign accept     = hsel && htrans_active(htrans) && hready_int;
  assign legal      = (hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00) &&
                      (haddr[31:4] == BASE_ADDR[31:4]);
  assign in_data    = (state_reg == ST_DATA) || (state_reg == ST_WAIT);
  assign wr_tx      = write_reg && (off_reg == REG_TXDATA);
  assign reg_wr     = (state_reg == ST_DATA) && write_reg;

  // A pop in the same cycle frees the entry the push needs.
  assign fifo_pop   = !fifo_empty && tx_ready;
  assign fifo_space = !fifo_full || fifo_pop;
  assign fifo_push  = in_data && wr_tx && fifo_space;

  assign hready_int = !((state_reg == ST_ERR1) || (in_data && wr_tx && !fifo_space));
  assign hready     = hready_int;
  assign hresp      = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ?
                      HRESP_ERROR : HRESP_OKAY;

  assign tx_valid   = !fifo_empty;
  assign i2c_go     = go_reg;
  assign i2c_rw     = rw_reg;
  assign i2c_addr   = slv_addr_reg;

  ahb_i2c_txfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_txfifo (
    .clk       (Hclk),
    .rst_n     (Hreset),
    .push      (fifo_push),
    .push_data (hwdata[7:0]),
    .pop       (fifo_pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A stalled TXDATA write parks in WAIT; otherwise the next state follows
  // whatever address phase is accepted alongside the current data phase.
  always_comb begin
    if (state_reg == ST_ERR1) begin
      state_next = ST_ERR2;
    end else if (!hready_int) begin
      state_next = ST_WAIT;
    end else if (accept) begin
      state_next = legal ? ST_DATA : ST_ERR1;
    end else begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    status_word                          = '0;
    status_word[STAT_EMPTY]              = fifo_empty;
    status_word[STAT_FULL]               = fifo_full;
    status_word[STAT_BUSY]               = i2c_busy;
    status_word[STAT_ACK_ERR]            = ack_err_reg;
    status_word[STAT_CNT_LSB +: 4]       = 4'(fifo_count);

    hrdata = '0;
    if ((state_reg == ST_DATA) && !write_reg) begin
      case (off_reg)
        REG_CTRL:     hrdata[CTRL_RW] = rw_reg;
        REG_STATUS:   hrdata = status_word;
        REG_SLV_ADDR: hrdata[6:0] = slv_addr_reg;
        default:      hrdata = '0;
      endcase
    end
  end

  always_ff @(posedge Hclk) begin
    if (!Hreset) begin
      state_reg    <= ST_IDLE;
      off_reg      <= '0;
      write_reg    <= 1'b0;
      rw_reg       <= 1'b0;
      slv_addr_reg <= '0;
      ack_err_reg  <= 1'b0;
      go_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        off_reg   <= haddr[3:2];
        write_reg <= hwrite;
      end
      go_reg <= reg_wr && (off_reg == REG_CTRL) && hwdata[CTRL_GO];
      if (reg_wr && (off_reg == REG_CTRL)) begin
        rw_reg <= hwdata[CTRL_RW];
      end
      if (reg_wr && (off_reg == REG_SLV_ADDR)) begin
        slv_addr_reg <= hwdata[6:0];
      end
      // A NACK arriving with a clearing write must not be lost.
      if (i2c_ack_err) begin
        ack_err_reg <= 1'b1;
      end else if (reg_wr && (off_reg == REG_STATUS) && hwdata[STAT_ACK_ERR]) begin
        ack_err_reg <= 1'b0;
      end
    end
  end

endmodule
